// File: rtl/spc_ram_host_loader_if.sv
// Byte-stream host link plus RAM control-port bundle for spc_ram_host_loader.
//   rx : in_rx_data / in_rx_valid / out_rx_ready   host -> loader command stream
//   tx : out_tx_data / out_tx_valid / in_tx_ready  loader -> host read-back stream
//   ctrl: out_ctrl_address / out_ctrl_data / out_ctrl_we / in_ctrl_data  RAM control port
// master: the loader side; slave: the host link and RAM side.
interface spc_ram_host_loader_if #(
  parameter int unsigned ADDRESS_BITS = 16
);
  logic [7:0]              in_rx_data;
  logic                    in_rx_valid;
  logic                    out_rx_ready;
  logic [7:0]              out_tx_data;
  logic                    out_tx_valid;
  logic                    in_tx_ready;
  logic [ADDRESS_BITS-1:0] out_ctrl_address;
  logic [7:0]              out_ctrl_data;
  logic                    out_ctrl_we;
  logic [7:0]              in_ctrl_data;

  modport master (
    input  in_rx_data, in_rx_valid, in_tx_ready, in_ctrl_data,
    output out_rx_ready, out_tx_data, out_tx_valid,
           out_ctrl_address, out_ctrl_data, out_ctrl_we
  );

  modport slave (
    output in_rx_data, in_rx_valid, in_tx_ready, in_ctrl_data,
    input  out_rx_ready, out_tx_data, out_tx_valid,
           out_ctrl_address, out_ctrl_data, out_ctrl_we
  );
endinterface

// File: rtl/spc_ram_host_loader.sv
// Host-side loader for the SPC700 audio RAM control port.
// Decodes a byte-stream command frame (OP, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO,
// payload) and either bulk-writes payload bytes into RAM or bulk-reads RAM
// and returns the bytes on the tx stream.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   bus          : rx/tx streams and RAM control port (master side)
//   out_busy     : high whenever the command engine is not idle
//   out_error    : sticky unknown-opcode flag, cleared only by reset
module spc_ram_host_loader #(
  parameter int unsigned ADDRESS_BITS = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  spc_ram_host_loader_if.master bus,
  output logic                  out_busy,
  output logic                  out_error
);

  localparam int unsigned LEN_BITS = 16;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_LEN_HI,
    S_LEN_LO,
    S_WR_DATA,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RD_SEND
  } state_t;

  state_t                  state;
  logic                    is_read;
  logic [7:0]              addr_hi_q;
  logic [7:0]              addr_lo_q;
  logic [7:0]              len_hi_q;
  // Bytes remaining minus one; zero means the current byte is the last.
  logic [LEN_BITS-1:0]     len_cnt;
  logic [ADDRESS_BITS-1:0] addr_q;
  logic [7:0]              wdata_q;
  logic                    we_q;
  logic [7:0]              tx_data_q;
  logic                    tx_valid_q;
  logic                    error_q;
  logic                    rx_ready;
  logic                    rx_fire;

  // The read path never consumes rx bytes.
  assign rx_ready = (state != S_RD_ISSUE) && (state != S_RD_WAIT) && (state != S_RD_SEND);
  assign rx_fire  = bus.in_rx_valid && rx_ready;

  assign bus.out_rx_ready     = rx_ready;
  assign bus.out_tx_data      = tx_data_q;
  assign bus.out_tx_valid     = tx_valid_q;
  assign bus.out_ctrl_address = addr_q;
  assign bus.out_ctrl_data    = wdata_q;
  assign bus.out_ctrl_we      = we_q;
  assign out_busy             = (state != S_IDLE);
  assign out_error            = error_q;

  // Command engine: header decode, write pulses, read issue/wait/send.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      is_read    <= 1'b0;
      addr_hi_q  <= 8'h00;
      addr_lo_q  <= 8'h00;
      len_hi_q   <= 8'h00;
      len_cnt    <= '0;
      addr_q     <= '0;
      wdata_q    <= 8'h00;
      we_q       <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      we_q <= 1'b0;
      // Address steps once the previous write pulse has been presented,
      // so back-to-back bytes land on consecutive addresses.
      if (we_q) begin
        addr_q <= addr_q + ADDRESS_BITS'(1);
      end

      case (state)
        S_IDLE: begin
          if (rx_fire) begin
            case (bus.in_rx_data)
              OP_WRITE: begin
                is_read <= 1'b0;
                state   <= S_ADDR_HI;
              end
              OP_READ: begin
                is_read <= 1'b1;
                state   <= S_ADDR_HI;
              end
              OP_NOP:  ;
              default: error_q <= 1'b1;
            endcase
          end
        end

        S_ADDR_HI: begin
          if (rx_fire) begin
            addr_hi_q <= bus.in_rx_data;
            state     <= S_ADDR_LO;
          end
        end

        S_ADDR_LO: begin
          if (rx_fire) begin
            addr_lo_q <= bus.in_rx_data;
            state     <= S_LEN_HI;
          end
        end

        S_LEN_HI: begin
          if (rx_fire) begin
            len_hi_q <= bus.in_rx_data;
            state    <= S_LEN_LO;
          end
        end

        S_LEN_LO: begin
          if (rx_fire) begin
            len_cnt <= {len_hi_q, bus.in_rx_data};
            addr_q  <= ADDRESS_BITS'({addr_hi_q, addr_lo_q});
            state   <= is_read ? S_RD_ISSUE : S_WR_DATA;
          end
        end

        // The last byte's pulse is emitted in the first idle cycle.
        S_WR_DATA: begin
          if (rx_fire) begin
            wdata_q <= bus.in_rx_data;
            we_q    <= 1'b1;
            if (len_cnt == '0) begin
              state <= S_IDLE;
            end else begin
              len_cnt <= len_cnt - LEN_BITS'(1);
            end
          end
        end

        S_RD_ISSUE: state <= S_RD_WAIT;

        // RAM output registered at the previous edge is valid now.
        S_RD_WAIT: begin
          tx_data_q  <= bus.in_ctrl_data;
          tx_valid_q <= 1'b1;
          state      <= S_RD_SEND;
        end

        S_RD_SEND: begin
          if (bus.in_tx_ready) begin
            tx_valid_q <= 1'b0;
            addr_q     <= addr_q + ADDRESS_BITS'(1);
            if (len_cnt == '0) begin
              state <= S_IDLE;
            end else begin
              len_cnt <= len_cnt - LEN_BITS'(1);
              state   <= S_RD_ISSUE;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/spc_ram_host_loader.md
Name: spc_ram_host_loader

Overview:
- Host-side initiator for the control port of the SPC700 audio RAM.
- Accepts a byte-stream command protocol (valid/ready) from a host link such as a UART or SPI bridge.
- Bulk-writes bytes into RAM, or bulk-reads RAM and returns bytes on a transmit stream.
- Sits between the host link and the RAM control port; loads sample/program images and reads back state without disturbing the APU port.

Parameters:
ADDRESS_BITS, 16, width of the RAM address; the address counter wraps modulo 2**ADDRESS_BITS.

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
in_rx_data  input  8  host command/data byte
in_rx_valid  input  1  in_rx_data valid
out_rx_ready  output  1  loader accepts byte; transfer occurs when valid&&ready at rising edge
out_tx_data  output  8  read-back byte to host
out_tx_valid  output  1  out_tx_data valid
in_tx_ready  input  1  host accepts byte
out_ctrl_address  output  ADDRESS_BITS  RAM control-port address (registered)
out_ctrl_data  output  8  RAM control-port write data (registered)
out_ctrl_we  output  1  RAM control-port write enable (registered, one-cycle pulses)
in_ctrl_data  input  8  RAM control-port read data; valid one clock after the address is sampled
out_busy  output  1  high in any state other than IDLE
out_error  output  1  sticky: an unknown opcode was received

Behaviour:
- Command frame: OP, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, then payload.
- OP=0x01 is write: LEN+1 payload bytes follow on rx.
- OP=0x02 is read: LEN+1 bytes are returned on tx.
- Byte count = {LEN_HI,LEN_LO}+1, so 0x0000 means 1 byte and 0xFFFF means 65536 bytes.
- Header address is {ADDR_HI,ADDR_LO}, truncated to ADDRESS_BITS.
- Address increments by 1 after each byte and wraps 0xFFFF -> 0x0000; the counter is not bounded by the start address.
- Reset values:
  - state=IDLE
  - out_ctrl_we=0, out_ctrl_address=0, out_ctrl_data=0
  - out_tx_valid=0, out_tx_data=0
  - out_error=0, out_busy=0
  - internal counters=0
- States: IDLE, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, WR_DATA, RD_ISSUE, RD_WAIT, RD_SEND.
- out_rx_ready: 1 in IDLE, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO and WR_DATA; 0 in all RD_* states.
- IDLE:
  - On accepted byte 0x01 or 0x02: latch opcode, go to ADDR_HI.
  - 0x00 is a NOP: stay in IDLE.
  - Any other value: set out_error=1, stay in IDLE.
- Header states advance one state per accepted byte.
- LEN_LO exits to WR_DATA (write) or RD_ISSUE (read), and loads out_ctrl_address with the start address.
- WR_DATA:
  - Each accepted byte registers out_ctrl_data=byte and out_ctrl_we=1 for exactly the next cycle, with out_ctrl_address equal to that byte's address.
  - Address advances after the pulse.
  - Back-to-back accepted bytes produce back-to-back we pulses at consecutive addresses (1 byte/cycle).
  - out_ctrl_we=0 in every cycle without an accepted byte.
  - After the last byte's pulse, return to IDLE.
- Read path (out_ctrl_we stays 0 throughout):
  - RD_ISSUE: address is stable on out_ctrl_address; go to RD_WAIT next cycle.
  - RD_WAIT: the RAM registers its output this edge. Next edge: capture in_ctrl_data into out_tx_data, set out_tx_valid=1, go to RD_SEND.
  - Latency from RD_ISSUE entry to out_tx_valid=1 is 2 cycles.
  - RD_SEND: hold out_tx_data and out_tx_valid stable until in_tx_ready=1. On that edge, clear out_tx_valid and increment the address.
  - After the handshake, go to RD_ISSUE if bytes remain, else IDLE.
  - Steady-state throughput is one byte per 3 cycles.
- No command abort other than reset. rx bytes presented in RD_* states are not consumed.
- Reset mid-operation: the next edge returns to IDLE with all outputs at reset values; the partial transfer is abandoned and RAM keeps already-written bytes.
- out_error is cleared only by reset.

Test Plan:
- Write: rx 01 12 34 00 02 AA BB CC, valid every cycle -> we pulses on 3 consecutive cycles at 0x1234/AA, 0x1235/BB, 0x1236/CC; then out_busy=0.
- Read-back: after the write above, rx 02 12 34 00 02 with in_tx_ready=1 -> tx AA, BB, CC; out_tx_valid rises 2 cycles after RD_ISSUE; out_ctrl_we never asserts.
- Wrap: write 01 FF FF 00 01 11 22 -> writes 0xFFFF=11, 0x0000=22; read 02 FF FF 00 01 returns 11, 22.
- Backpressure:
  - Read 1 byte with in_tx_ready=0 for 10 cycles -> out_tx_valid and out_tx_data hold constant and the address does not change; byte completes when ready=1.
  - Write with in_rx_valid gapped -> no we pulse in gap cycles.
- Bad opcode: rx 7F -> out_error=1 and state stays IDLE; following 00 is ignored; a valid 01 command still executes; only reset clears out_error.
- Reset mid-write: assert reset after 2 of 4 payload bytes -> next edge out_busy=0 and we=0; RAM holds the 2 written bytes; a fresh command after reset behaves normally.
